// File: rtl/fmul_arbiter.sv
// fmul_arbiter: shares one multi-cycle fmul among N_REQ requesters.
// Grant is fixed priority by default; define FMUL_ARBITER_RR_EN for round-robin.
module fmul_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [32*N_REQ-1:0]   req_x1,
  input  logic [32*N_REQ-1:0]   req_x2,
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_REQ-1:0]      resp_valid,
  output logic [31:0]           resp_y,
  input  logic [N_REQ-1:0]      resp_ready,
  output logic [31:0]           fm_x1,
  output logic [31:0]           fm_x2,
  output logic                  fm_ready,
  input  logic                  fm_valid,
  input  logic [31:0]           fm_y,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  state_t           state, next_state;
  logic [31:0]      op_x1, op_x2, result;
  logic [31:0]      sel_x1, sel_x2;
  logic [IDW-1:0]   grant_idx, gnt_reg;
  logic [N_REQ-1:0] grant_oh, gnt_reg_oh;
  logic             accept;

`ifdef FMUL_ARBITER_RR_EN
  logic [IDW-1:0] last_ptr;

  // Scan descending so the nearest requester after last_ptr overwrites last.
  always_comb begin
    int cand;
    grant_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = (int'(last_ptr) + 1 + k) % N_REQ;
      if (req_valid[cand]) grant_idx = IDW'(cand);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         last_ptr <= IDW'(N_REQ - 1);
    else if (accept) last_ptr <= grant_idx;
  end
`else
  always_comb begin
    grant_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req_valid[k]) grant_idx = IDW'(k);
  end
`endif

  assign grant_oh   = ONE_HOT0 << grant_idx;
  assign gnt_reg_oh = ONE_HOT0 << gnt_reg;
  assign accept     = (state == IDLE) && (|req_valid) && !rst;

  always_comb begin
    sel_x1 = '0;
    sel_x2 = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_idx == IDW'(k)) begin
        sel_x1 = req_x1[32*k +: 32];
        sel_x2 = req_x2[32*k +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // req_ready is also masked by rst so no requester sees a transfer that reset discards.
  always_comb begin
    next_state = state;
    req_ready  = '0;
    resp_valid = '0;
    fm_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid && !rst) begin
          req_ready  = grant_oh;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        fm_ready   = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        if (fm_valid) next_state = RESP;
      end
      RESP: begin
        resp_valid = gnt_reg_oh;
        if (resp_ready[gnt_reg]) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operands stay registered until the next accept, so fmul inputs never move mid-op.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_x1   <= '0;
      op_x2   <= '0;
      result  <= '0;
      gnt_reg <= '0;
    end else begin
      if (accept) begin
        op_x1   <= sel_x1;
        op_x2   <= sel_x2;
        gnt_reg <= grant_idx;
      end
      if (state == WAIT && fm_valid) result <= fm_y;
    end
  end

  assign fm_x1  = op_x1;
  assign fm_x2  = op_x2;
  assign resp_y = result;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_fmul_arbiter.sv
// tb_fmul_arbiter: directed, table-driven bench with a behavioural one-cycle fmul.
// Covers both grant modes, selected by FMUL_ARBITER_RR_EN.
module tb_fmul_arbiter;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [32*N-1:0]   req_x1, req_x2;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      resp_valid;
  logic [31:0]       resp_y;
  logic [N-1:0]      resp_ready;
  logic [31:0]       fm_x1, fm_x2;
  logic              fm_ready;
  logic              fm_valid;
  logic [31:0]       fm_y;
  logic              busy;
  logic              fm_inject;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          idx;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] y;
  } vec_t;

  vec_t vecs[5];

  fmul_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_x1    (req_x1),
    .req_x2    (req_x2),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_y    (resp_y),
    .resp_ready(resp_ready),
    .fm_x1     (fm_x1),
    .fm_x2     (fm_x2),
    .fm_ready  (fm_ready),
    .fm_valid  (fm_valid),
    .fm_y      (fm_y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40000000, 32'h40400000}: return 32'h40C00000;
      {32'h00000000, 32'hC0000000}: return 32'h80000000;
      {32'h3F800000, 32'h3F800000}: return 32'h3F800000;
      {32'h40400000, 32'h40400000}: return 32'h41100000;
      {32'hBF800000, 32'h40000000}: return 32'hC0000000;
      default:                      return a ^ {b[15:0], b[31:16]};
    endcase
  endfunction

  // Shared fmul: answers one cycle after the start strobe; fm_inject forces a stray done.
  initial begin
    logic seen;
    seen     = 1'b0;
    fm_valid = 1'b0;
    fm_y     = '0;
    forever begin
      @(negedge clk);
      fm_valid = seen | fm_inject;
      fm_y     = fm_inject ? 32'hDEADBEEF : fmul_model(fm_x1, fm_x2);
      seen     = fm_ready & ~rst;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One full transaction on lane idx, optionally holding resp_ready low for hold cycles.
  task automatic apply_stimulus(input int idx, input logic [31:0] x1, input logic [31:0] x2,
                                input logic [31:0] y, input int hold, input string tag);
    logic [N-1:0] oh;
    oh = N'(1) << idx;
    req_x1[32*idx +: 32] = x1;
    req_x2[32*idx +: 32] = x2;
    req_valid = oh;
    #1 check_output({tag, " T req_ready"}, 32'(req_ready), 32'(oh));
    @(posedge clk); #1;
    req_valid = '0;
    check_output({tag, " T+1 fm_ready"}, 32'(fm_ready), 32'd1);
    check_output({tag, " T+1 req_ready"}, 32'(req_ready), 32'd0);
    check_output({tag, " T+1 busy"}, 32'(busy), 32'd1);
    check_output({tag, " T+1 fm_x1"}, fm_x1, x1);
    check_output({tag, " T+1 fm_x2"}, fm_x2, x2);
    @(posedge clk); #1;
    check_output({tag, " T+2 fm_ready"}, 32'(fm_ready), 32'd0);
    check_output({tag, " T+2 fm_x1"}, fm_x1, x1);
    check_output({tag, " T+2 fm_x2"}, fm_x2, x2);
    check_output({tag, " T+2 resp_valid"}, 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    check_output({tag, " T+3 resp_valid"}, 32'(resp_valid), 32'(oh));
    check_output({tag, " T+3 resp_y"}, resp_y, y);
    for (int h = 0; h < hold; h++) begin
      req_valid  = ~oh;
      resp_ready = ~oh;
      #1 check_output($sformatf("%s hold%0d req_ready", tag, h), 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      check_output($sformatf("%s hold%0d resp_valid", tag, h), 32'(resp_valid), 32'(oh));
      check_output($sformatf("%s hold%0d resp_y", tag, h), resp_y, y);
      check_output($sformatf("%s hold%0d busy", tag, h), 32'(busy), 32'd1);
    end
    req_valid  = '0;
    resp_ready = oh;
    @(posedge clk); #1;
    resp_ready = '0;
    check_output({tag, " done busy"}, 32'(busy), 32'd0);
    check_output({tag, " done resp_valid"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [N-1:0] pattern;
    int           exp_order[5];

    vecs[0] = '{idx: 0, x1: 32'h40000000, x2: 32'h40400000, y: 32'h40C00000};
    vecs[1] = '{idx: 3, x1: 32'h00000000, x2: 32'hC0000000, y: 32'h80000000};
    vecs[2] = '{idx: 1, x1: 32'h3F800000, x2: 32'h3F800000, y: 32'h3F800000};
    vecs[3] = '{idx: 2, x1: 32'h40400000, x2: 32'h40400000, y: 32'h41100000};
    vecs[4] = '{idx: 3, x1: 32'hBF800000, x2: 32'h40000000, y: 32'hC0000000};

    rst        = 1'b1;
    req_valid  = '0;
    req_x1     = '0;
    req_x2     = '0;
    resp_ready = '0;
    fm_inject  = 1'b0;

    @(posedge clk); #1;
    check_output("reset busy", 32'(busy), 32'd0);
    check_output("reset req_ready", 32'(req_ready), 32'd0);
    check_output("reset resp_valid", 32'(resp_valid), 32'd0);
    check_output("reset fm_ready", 32'(fm_ready), 32'd0);
    check_output("reset resp_y", resp_y, 32'd0);
    check_output("reset fm_x1", fm_x1, 32'd0);
    check_output("reset fm_x2", fm_x2, 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 5; v++)
      apply_stimulus(vecs[v].idx, vecs[v].x1, vecs[v].x2, vecs[v].y, 0, $sformatf("vec%0d", v));

    apply_stimulus(2, 32'h40000000, 32'h40400000, 32'h40C00000, 5, "backpressure");

    // Requester withdraws before the edge: no grant, no operation.
    req_valid = 4'b0100;
    #1 check_output("drop req_ready before", 32'(req_ready), 32'b0100);
    req_valid = '0;
    #1 check_output("drop req_ready after", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check_output("drop busy", 32'(busy), 32'd0);

    // Stray fmul done while idle must not disturb the result register.
    fm_inject = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_output($sformatf("stray%0d busy", c), 32'(busy), 32'd0);
      check_output($sformatf("stray%0d resp_y", c), resp_y, 32'h40C00000);
    end
    fm_inject = 1'b0;
    @(posedge clk); #1;

    // Reset during WAIT drops the operation without a response.
    req_x1[0 +: 32] = 32'h3F800000;
    req_x2[0 +: 32] = 32'h3F800000;
    req_valid = 4'b0001;
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    check_output("midrst in WAIT busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_output("midrst busy", 32'(busy), 32'd0);
    check_output("midrst fm_x1", fm_x1, 32'd0);
    check_output("midrst resp_y", resp_y, 32'd0);
    for (int c = 0; c < 3; c++) begin
      check_output($sformatf("midrst%0d resp_valid", c), 32'(resp_valid), 32'd0);
      @(posedge clk); #1;
    end
    apply_stimulus(vecs[0].idx, vecs[0].x1, vecs[0].x2, vecs[0].y, 0, "after_rst");

`ifdef FMUL_ARBITER_RR_EN
    pattern   = 4'b1111;
    exp_order = '{0, 1, 2, 3, 0};
`else
    pattern   = 4'b1010;
    exp_order = '{1, 1, 1, 1, 1};
`endif
    do_reset();
    req_valid  = pattern;
    resp_ready = '1;
    for (int k = 0; k < 5; k++) begin
      for (int w = 0; w < 8 && req_ready == '0; w++) begin
        @(posedge clk); #1;
      end
      check_output($sformatf("contention grant%0d", k), 32'(req_ready),
                   32'(N'(1) << exp_order[k]));
      @(posedge clk); #1;
    end
    req_valid = '0;
    for (int w = 0; w < 8 && busy; w++) begin
      @(posedge clk); #1;
    end
    check_output("contention drain busy", 32'(busy), 32'd0);
    resp_ready = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fmul_arbiter.md
FMUL_ARBITER -- requirements
Module: fmul_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of requesters sharing one fmul (legal range 2..8).
REQ-002 The block SHALL have parameter IDW, default $clog2(N_REQ), requester index width.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port req_valid  input  N_REQ  per-requester operation request.
REQ-006 The block SHALL have port req_x1  input  32*N_REQ  packed operand 1; requester i uses bits [32i+31:32i].
REQ-007 The block SHALL have port req_x2  input  32*N_REQ  packed operand 2, same packing as req_x1.
REQ-008 The block SHALL have port req_ready  output  N_REQ  one-hot accept; a request transfers when req_valid[i] and req_ready[i] are both 1 on the same edge.
REQ-009 The block SHALL have port resp_valid  output  N_REQ  one-hot result-available flag.
REQ-010 The block SHALL have port resp_y  output  32  product, valid while any resp_valid bit is 1.
REQ-011 The block SHALL have port resp_ready  input  N_REQ  per-requester result accept.
REQ-012 The block SHALL have port fm_x1, fm_x2  output  32 each  operands to the shared fmul.
REQ-013 The block SHALL have port fm_ready  output  1  start strobe to fmul.
REQ-014 The block SHALL have port fm_valid  input  1  fmul done; fm_y  input  32  fmul result.
REQ-015 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE SHALL assert req_ready only for the granted index g, combinationally, when at least one req_valid is set; on acceptance it latches req_x1/x2[g] and g, then moves to ISSUE.
REQ-018 ISSUE SHALL assert fm_ready for exactly one cycle, then move to WAIT.
REQ-019 WAIT SHALL hold fm_ready low; on fm_valid it captures fm_y into the result register and moves to RESP.
REQ-020 RESP SHALL assert resp_valid[g] with resp_y stable until resp_ready[g]; on that edge it moves to IDLE. resp_ready of other indices SHALL be ignored.
REQ-021 fm_x1/fm_x2 SHALL hold the latched operands unchanged from ISSUE through the WAIT cycle in which fm_valid is sampled, because fmul computes sign and exponent combinationally from its inputs.
REQ-022 Latency SHALL be: accept at T, fm_ready at T+1, fm_valid at T+2, resp_valid at T+3; minimum issue interval 4 cycles.
REQ-023 req_ready SHALL be all-zero in ISSUE, WAIT and RESP; a requester dropping req_valid before acceptance SHALL receive no grant.
REQ-024 fm_valid outside WAIT SHALL be ignored.
REQ-025 The grant pointer SHALL update only on an accepted request.

Reset
REQ-026 On rst the block SHALL enter IDLE with req_ready=0, resp_valid=0, fm_ready=0, busy=0, resp_y=0, fm_x1=fm_x2=0, and the last-grant pointer set to N_REQ-1.
REQ-027 rst mid-operation SHALL discard the in-flight operation with no response; the integrator SHALL reset the shared fmul in the same cycle (rstn = ~rst).

Configuration
REQ-028 With macro FMUL_ARBITER_RR_EN defined, grant SHALL be round-robin: the first requesting index after the last granted index, wrapping from N_REQ-1 to 0.
REQ-029 Without FMUL_ARBITER_RR_EN, grant SHALL be fixed priority (lowest requesting index wins) and the pointer SHALL be omitted.

Verification
REQ-030 Single op: req_valid=0001, x1=0x40000000, x2=0x40400000 -> req_ready=0001 at T, fm_ready at T+1, resp_valid=0001, resp_y=0x40C00000 at T+3.
REQ-031 Contention (RR_EN): req_valid=1111 held -> grant order 0,1,2,3,0; no index granted twice before all others are served.
REQ-032 Contention (no RR_EN): req_valid=1010 held -> index 1 granted every time, index 3 never.
REQ-033 Backpressure: resp_ready low for 5 cycles in RESP -> resp_valid and resp_y stable, req_ready=0, busy=1 throughout.
REQ-034 Reset mid-op: rst asserted in WAIT -> next cycle IDLE, resp_valid=0, no response delivered; a fresh op then completes normally with the same T..T+3 timing.
REQ-035 Zero operand: x1=0x00000000, x2=0xC0000000 -> resp_y=0x80000000; fm_x1/fm_x2 unchanged until fm_valid is sampled.
